pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the PC and branch-target width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-005 pc_sel  input  1  SHALL be the branch-taken redirect from the branch controller.
REQ-006 branch_target  input  WIDTH  SHALL be the redirect address, sampled when pc_sel=1.
REQ-007 imem_req  output  1  SHALL be the instruction-memory request.
REQ-008 imem_addr  output  WIDTH  SHALL be the request address, word aligned.
REQ-009 imem_gnt  input  1  SHALL be the memory's acceptance of the request.
REQ-010 imem_rvalid  input  1  SHALL mark a valid read response.
REQ-011 imem_rdata  input  32  SHALL be the response instruction word.
REQ-012 instr_valid  output  1  SHALL mark a valid instruction presented to decode.
REQ-013 instr_ready  input  1  SHALL be decode's acceptance.
REQ-014 instr_out  output  32  SHALL be the fetched instruction.
REQ-015 pc_out  output  WIDTH  SHALL be the address of instr_out.

Function
REQ-016 FSM SHALL have states FETCH (imem_req=1), WAIT (request granted, response pending) and HOLD (instruction presented, not yet accepted).
REQ-017 FETCH: imem_req=1, imem_addr=pc; imem_addr SHALL stay stable until imem_gnt=1; on grant go to WAIT.
REQ-018 At most one request SHALL be outstanding; imem_req SHALL be 0 in WAIT and HOLD.
REQ-019 WAIT with imem_rvalid=1: latch instr_out=imem_rdata and pc_out=request address, assert instr_valid next cycle, go to HOLD.
REQ-020 HOLD: instr_out, pc_out and instr_valid SHALL stay stable until instr_ready=1; on acceptance pc <= pc+4 and go to FETCH.
REQ-021 Fetch-to-decode latency SHALL be 1 cycle after imem_rvalid; a 0-wait memory (gnt in FETCH, rvalid the following cycle) SHALL yield one instruction per 3 cycles.
REQ-022 PC increment SHALL wrap modulo 2^WIDTH (pc=32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 branch_target[1:0] SHALL be ignored; the redirected pc SHALL be {branch_target[WIDTH-1:2],2'b00}.
REQ-024 pc_sel=1 in FETCH without grant: pc <= target; imem_addr SHALL change to target next cycle (the only case where the address changes before grant).
REQ-025 pc_sel=1 in FETCH with imem_gnt=1: set discard flag, pc <= target, go to WAIT; the granted stale response SHALL be dropped.
REQ-026 pc_sel=1 in WAIT (including the same cycle as imem_rvalid): set discard; pc <= target; the pending response SHALL not reach instr_valid.
REQ-027 WAIT with discard=1 and imem_rvalid=1: clear discard, go to FETCH at the redirected pc.
REQ-028 pc_sel=1 in HOLD: instr_valid SHALL drop next cycle regardless of instr_ready, pc <= target, go to FETCH.
REQ-029 pc_sel SHALL take priority over instr_ready and imem_rvalid in the same cycle.
REQ-030 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force state FETCH, pc=RESET_PC, discard=0, instr_valid=0, instr_out=0, pc_out=0.
REQ-032 During reset imem_req SHALL be 0; in the first cycle after release imem_req=1 with imem_addr=RESET_PC.
REQ-033 Reset mid-WAIT SHALL abandon the outstanding response; a late imem_rvalid after release SHALL be ignored by REQ-030.

Verification
REQ-034 Reset release, 0-wait memory returning 0x00000013 -> imem_addr sequence 0x0,0x4,0x8, instr_valid with pc_out=0x0 and instr_out=0x00000013 in the 3rd cycle after release.
REQ-035 instr_ready low 5 cycles in HOLD -> instr_out, pc_out and instr_valid constant; no imem_req until acceptance.
REQ-036 pc_sel=1, branch_target=0x103 in WAIT -> stale response dropped, next imem_addr=0x100, no instr_valid for the old pc.
REQ-037 pc_sel and imem_rvalid in the same cycle -> response discarded, next fetch at target.
REQ-038 pc=0xFFFFFFFC accepted -> next imem_addr=0x00000000.
REQ-039 rst_n low mid-WAIT, imem_rvalid one cycle after release -> instr_valid stays 0, fetch at RESET_PC.

Source files
------------

// File: rtl/pc_fetch.sv
// Instruction fetch unit: issues one instruction-memory request at a time and
// presents each response to decode, dropping responses that a branch redirect made stale.
module pc_fetch #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_sel,
  input  logic [WIDTH-1:0] branch_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr_out,
  output logic [WIDTH-1:0] pc_out
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             discard_q, discard_d;
  logic             valid_q, valid_d;
  logic [31:0]      instr_q, instr_d;
  logic [WIDTH-1:0] pc_out_q, pc_out_d;
  logic [WIDTH-1:0] target;

  assign target = branch_target & ALIGN_MASK;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC & ALIGN_MASK;
      discard_q <= 1'b0;
      valid_q   <= 1'b0;
      instr_q   <= 32'h0;
      pc_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc_out_q  <= pc_out_d;
    end
  end

  // A redirect always wins; a response already granted under the old pc is
  // marked for discard so it can never reach decode.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    unique case (state_q)
      S_FETCH: begin
        if (pc_sel) pc_d = target;
        if (imem_gnt) begin
          state_d   = S_WAIT;
          discard_d = pc_sel;
        end
      end
      S_WAIT: begin
        if (pc_sel) pc_d = target;
        if (imem_rvalid) begin
          discard_d = 1'b0;
          if (pc_sel || discard_q) begin
            state_d = S_FETCH;
          end else begin
            state_d  = S_HOLD;
            valid_d  = 1'b1;
            instr_d  = imem_rdata;
            pc_out_d = pc_q;
          end
        end else if (pc_sel) begin
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (pc_sel) begin
          pc_d    = target;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end else if (instr_ready) begin
          pc_d    = pc_q + WIDTH'(4);
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Request is gated by rst_n so nothing is issued while reset is held.
  assign imem_req    = rst_n && (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios followed by randomized traffic, all
// checked each cycle against a transaction-level model of the fetch stream.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_sel;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;

  // Model: next fetch address, one outstanding request (possibly stale),
  // and the instruction currently offered to decode.
  bit          mOut;
  bit          mStale;
  bit          mValid;
  logic [31:0] mOutAddr;
  logic [31:0] mPcOut;
  logic [31:0] mInstr;
  logic [31:0] mPc;
  bit          checkOn;
  int          assertCount;
  int          failCount;
  int          delayCnt;

  pc_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_sel       (pc_sel),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_out    (instr_out),
    .pc_out       (pc_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs at the negedge, checks outputs against the
  // model, advances the model across the next posedge.
  task automatic applyStimulus(input logic rstn, input logic gnt, input logic rv,
                               input logic [31:0] rd, input logic sel,
                               input logic [31:0] tgt, input logic rdy);
    logic        mReq;
    logic        nextValid;
    logic [31:0] nextPc;
    rst_n         = rstn;
    imem_gnt      = gnt;
    imem_rvalid   = rv;
    imem_rdata    = rd;
    pc_sel        = sel;
    branch_target = tgt;
    instr_ready   = rdy;
    #1;
    mReq = rstn && !mValid && !mOut;
    if (checkOn) begin
      checkOutput("imem_req", 32'(imem_req), 32'(mReq));
      if (mReq) checkOutput("imem_addr", imem_addr, mPc);
      checkOutput("instr_valid", 32'(instr_valid), 32'(mValid));
      checkOutput("pc_out", pc_out, mPcOut);
      checkOutput("instr_out", instr_out, mInstr);
    end
    if (!rstn) begin
      mOut   = 1'b0;
      mStale = 1'b0;
      mValid = 1'b0;
      mPcOut = 32'h0;
      mInstr = 32'h0;
      mPc    = 32'h0;
    end else begin
      nextValid = mValid && !rdy && !sel;
      if (sel) nextPc = tgt & 32'hFFFF_FFFC;
      else if (mValid && rdy) nextPc = mPcOut + 32'd4;
      else nextPc = mPc;
      if (mOut && rv) begin
        if (!mStale && !sel) begin
          nextValid = 1'b1;
          mPcOut    = mOutAddr;
          mInstr    = rd;
        end
        mOut   = 1'b0;
        mStale = 1'b0;
      end else if (mOut && sel) begin
        mStale = 1'b1;
      end else if (mReq && gnt) begin
        mOut     = 1'b1;
        mOutAddr = mPc;
        mStale   = sel;
      end
      mPc    = nextPc;
      mValid = nextValid;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic        rRst, rGnt, rRv, rSel, rRdy, granted;
    logic [31:0] rRd, rTgt;
    assertCount = 0;
    failCount   = 0;
    checkOn     = 1'b0;
    delayCnt    = 0;

    // Reset, then zero-wait memory returning addi x0,x0,0.
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0);
    checkOn = 1'b1;
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("reset_req", 32'(imem_req), 32'h0);
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(1, 0, 1, 32'h0000_0013, 0, 32'h0, 0);
    checkOutput("first_valid", 32'(instr_valid), 32'h1);
    checkOutput("first_pc", pc_out, 32'h0);
    checkOutput("first_instr", instr_out, 32'h0000_0013);
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("second_addr", imem_addr, 32'h4);
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(1, 0, 1, 32'h0000_0013, 0, 32'h0, 0);
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("third_addr", imem_addr, 32'h8);

    // Decode stalls for five cycles while an instruction is held.
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(1, 0, 1, 32'hDEAD_BEEF, 0, 32'h0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 0);
      checkOutput("hold_instr", instr_out, 32'hDEAD_BEEF);
      checkOutput("hold_req", 32'(imem_req), 32'h0);
    end
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 1);

    // Redirect while waiting: unaligned target, stale response dropped.
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(1, 0, 0, 32'h0, 1, 32'h0000_0103, 0);
    applyStimulus(1, 0, 1, 32'h0000_0BAD, 0, 32'h0, 1);
    checkOutput("wait_redirect_valid", 32'(instr_valid), 32'h0);
    checkOutput("wait_redirect_addr", imem_addr, 32'h100);

    // Redirect in the same cycle as the response.
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(1, 0, 1, 32'h0000_0BAD, 1, 32'h0000_0200, 1);
    checkOutput("same_cycle_valid", 32'(instr_valid), 32'h0);
    checkOutput("same_cycle_addr", imem_addr, 32'h200);

    // Redirect in FETCH without grant, then with grant.
    applyStimulus(1, 0, 0, 32'h0, 1, 32'h0000_0301, 0);
    checkOutput("fetch_redirect_addr", imem_addr, 32'h300);
    applyStimulus(1, 1, 0, 32'h0, 1, 32'h0000_0400, 0);
    applyStimulus(1, 0, 1, 32'h0000_0BAD, 0, 32'h0, 1);
    checkOutput("grant_redirect_addr", imem_addr, 32'h400);

    // Redirect in HOLD beats instr_ready.
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(1, 0, 1, 32'h0000_1234, 0, 32'h0, 0);
    applyStimulus(1, 0, 0, 32'h0, 1, 32'h0000_0500, 1);
    checkOutput("hold_redirect_valid", 32'(instr_valid), 32'h0);
    checkOutput("hold_redirect_addr", imem_addr, 32'h500);

    // PC wraps past the top of the address space.
    applyStimulus(1, 0, 0, 32'h0, 1, 32'hFFFF_FFFF, 0);
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(1, 0, 1, 32'h0000_5678, 0, 32'h0, 0);
    checkOutput("top_pc", pc_out, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("wrap_addr", imem_addr, 32'h0);

    // Reset mid-WAIT with a late response right after release.
    applyStimulus(1, 0, 1, 32'h0, 1, 32'h0000_0040, 0);
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(1, 0, 1, 32'h0000_0BAD, 0, 32'h0, 1);
    checkOutput("late_rvalid_valid", 32'(instr_valid), 32'h0);
    checkOutput("late_rvalid_addr", imem_addr, 32'h0);

    // Randomized traffic with variable memory latency and spurious rvalid.
    for (int i = 0; i < 1500; i++) begin
      rRst = 1'($urandom_range(0, 199) != 0);
      rGnt = 1'($urandom_range(0, 2) != 0);
      if (mOut) begin
        if (delayCnt == 0) begin
          rRv = 1'b1;
        end else begin
          rRv = 1'b0;
          delayCnt--;
        end
      end else begin
        rRv = 1'($urandom_range(0, 9) == 0);
      end
      rSel    = 1'($urandom_range(0, 7) == 0);
      rRdy    = 1'($urandom_range(0, 1));
      rRd     = $urandom;
      rTgt    = $urandom;
      granted = rRst && rGnt && !mValid && !mOut;
      applyStimulus(rRst, rGnt, rRv, rRd, rSel, rTgt, rRdy);
      if (granted) delayCnt = $urandom_range(0, 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
